// File: rtl/jtcps1_pkg.sv
// Shared constants for the CPS1 interrupt generator: default IPL levels,
// raster counter reset value and the IPL priority encoder.
package jtcps1_pkg;

  localparam logic [2:0] VINT_LVL_DEF = 3'd2;
  localparam logic [2:0] RINT_LVL_DEF = 3'd4;
  localparam logic [8:0] RCNT_RST     = 9'h1FF;

  // Raster outranks vblank; the 68000 expects the level inverted on IPL.
  function automatic logic [2:0] ipl_enc(input logic rint, input logic vint,
                                         input logic [2:0] rlvl, input logic [2:0] vlvl);
    logic [2:0] ipl;
    ipl = 3'b111;
    if (rint)      ipl = ~rlvl;
    else if (vint) ipl = ~vlvl;
    return ipl;
  endfunction

endpackage

// File: rtl/jtcps1_irqgen_if.sv
// CPU-side bus of the interrupt generator: raster register write,
// interrupt acknowledge, IPL lines and frame counter readback.
interface jtcps1_irqgen_if;
  logic       raster_we;
  logic [8:0] raster_din;
  logic       iack;
  logic [2:0] iack_lvl;
  logic [2:0] ipl_n;
  logic [7:0] frame_cnt;

  modport master (output raster_we, raster_din, iack, iack_lvl,
                  input  ipl_n, frame_cnt);
  modport slave  (input  raster_we, raster_din, iack, iack_lvl,
                  output ipl_n, frame_cnt);
endinterface

// File: rtl/jtcps1_edge.sv
// Clock-enable gated rising-edge detector. History only advances on cen
// cycles and resets to rst_val_i so a level already high at reset is not an edge.
module jtcps1_edge (
  input  logic clk,
  input  logic rst_n,
  input  logic cen_i,
  input  logic sig_i,
  input  logic rst_val_i,
  output logic rise_o
);

  logic hist_q;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n)     hist_q <= rst_val_i;
    else if (cen_i) hist_q <= sig_i;
  end

  assign rise_o = cen_i & sig_i & ~hist_q;

endmodule

// File: rtl/jtcps1_irqgen.sv
// CPS1 68000 interrupt generator: vblank and raster-line interrupts.
// Raster logic is present only when JTCPS1_RASTER_EN is defined.
module jtcps1_irqgen
  import jtcps1_pkg::*;
#(
  parameter logic [2:0] VINT_LEVEL = VINT_LVL_DEF,
  parameter logic [2:0] RINT_LEVEL = RINT_LVL_DEF
)(
  input  logic           clk,
  input  logic           rst_n,
  input  logic           cen8,
  input  logic           VB,
  input  logic           start,
  jtcps1_irqgen_if.slave bus
);

  logic       vb_rise;
  logic       vint_q, vint_d;
  logic       rint_q;
  logic [7:0] fcnt_q, fcnt_d;
  logic [2:0] ipl_q,  ipl_d;
  logic       iack_v;

  jtcps1_edge u_vb_edge (
    .clk       (clk),
    .rst_n     (rst_n),
    .cen_i     (cen8),
    .sig_i     (VB),
    .rst_val_i (1'b1),
    .rise_o    (vb_rise)
  );

  assign iack_v = bus.iack && (bus.iack_lvl == VINT_LEVEL);

  // A set wins over an acknowledge landing on the same clk.
  always_comb begin
    vint_d = vb_rise | (vint_q & ~iack_v);
    fcnt_d = fcnt_q + {7'd0, vb_rise};
    ipl_d  = ipl_enc(rint_q, vint_q, RINT_LEVEL, VINT_LEVEL);
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      vint_q <= 1'b0;
      fcnt_q <= 8'd0;
      ipl_q  <= 3'b111;
    end else begin
      vint_q <= vint_d;
      fcnt_q <= fcnt_d;
      ipl_q  <= ipl_d;
    end
  end

`ifdef JTCPS1_RASTER_EN
  logic       iack_r;
  logic       rint_d, rint_set;
  logic [8:0] rcnt_q,  rcnt_d;
  logic [8:0] rload_q, rload_d;

  assign iack_r = bus.iack && (bus.iack_lvl == RINT_LEVEL);

  // CPU write beats a coincident line start; reload happens on the firing line.
  always_comb begin
    rload_d  = rload_q;
    rcnt_d   = rcnt_q;
    rint_set = 1'b0;
    if (bus.raster_we) begin
      rload_d = bus.raster_din;
      rcnt_d  = bus.raster_din;
    end else if (cen8 && start) begin
      if (rcnt_q == 9'd0) begin
        rint_set = 1'b1;
        rcnt_d   = rload_q;
      end else begin
        rcnt_d = rcnt_q - 9'd1;
      end
    end
    rint_d = rint_set | (rint_q & ~iack_r);
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      rcnt_q  <= RCNT_RST;
      rload_q <= RCNT_RST;
      rint_q  <= 1'b0;
    end else begin
      rcnt_q  <= rcnt_d;
      rload_q <= rload_d;
      rint_q  <= rint_d;
    end
  end
`else
  logic unused_raster;
  assign rint_q        = 1'b0;
  assign unused_raster = &{1'b0, start, bus.raster_we, bus.raster_din};
`endif

  assign bus.ipl_n     = ipl_q;
  assign bus.frame_cnt = fcnt_q;

endmodule

// File: tb/tb_jtcps1_irqgen.sv
// Scoreboard bench for jtcps1_irqgen; raster scenarios run when
// JTCPS1_RASTER_EN is defined, the raster-absent scenario otherwise.
module tb_jtcps1_irqgen;

  typedef struct {
    string      name;
    logic [2:0] ipl;
    logic [7:0] fc;
  } exp_t;

  logic clk = 1'b0;
  logic rst_n, cen8, VB, start;
  int   n_chk = 0;
  int   n_err = 0;
  logic [7:0] exp_fc = 8'd0;
  exp_t exp_q[$];
  exp_t e;

  jtcps1_irqgen_if bus();

  jtcps1_irqgen dut (
    .clk   (clk),
    .rst_n (rst_n),
    .cen8  (cen8),
    .VB    (VB),
    .start (start),
    .bus   (bus.slave)
  );

  always #5 clk = ~clk;

  task automatic cyc(input int n = 1);
    repeat (n) begin
      @(posedge clk);
      #1;
    end
  endtask

  task automatic vb_edge();
    VB = 1'b0; cyc(2);
    VB = 1'b1; cyc(2);
    exp_fc = exp_fc + 8'd1;
  endtask

  task automatic ack(input logic [2:0] lvl);
    bus.iack = 1'b1; bus.iack_lvl = lvl; cyc();
    bus.iack = 1'b0; cyc();
  endtask

  task automatic test_reset();
    rst_n = 1'b0; VB = 1'b1; cyc(3);
    exp_q.push_back('{"reset", 3'b111, 8'd0});
    e = exp_q.pop_front(); n_chk += 2;
    if (bus.ipl_n !== e.ipl) begin n_err++; $display("FAIL %s ipl_n=%b want %b", e.name, bus.ipl_n, e.ipl); end
    if (bus.frame_cnt !== e.fc) begin n_err++; $display("FAIL %s frame_cnt=%0d want %0d", e.name, bus.frame_cnt, e.fc); end
    rst_n = 1'b1; cyc(4);
    exp_q.push_back('{"vb_high_release", 3'b111, 8'd0});
    e = exp_q.pop_front(); n_chk += 2;
    if (bus.ipl_n !== e.ipl) begin n_err++; $display("FAIL %s ipl_n=%b want %b", e.name, bus.ipl_n, e.ipl); end
    if (bus.frame_cnt !== e.fc) begin n_err++; $display("FAIL %s frame_cnt=%0d want %0d", e.name, bus.frame_cnt, e.fc); end
  endtask

  task automatic test_vblank();
    VB = 1'b0; cyc(3);
    VB = 1'b1; exp_fc = 8'd1;
    exp_q.push_back('{"vb_edge_same_clk", 3'b111, 8'd1});
    cyc();
    e = exp_q.pop_front(); n_chk += 2;
    if (bus.ipl_n !== e.ipl) begin n_err++; $display("FAIL %s ipl_n=%b want %b", e.name, bus.ipl_n, e.ipl); end
    if (bus.frame_cnt !== e.fc) begin n_err++; $display("FAIL %s frame_cnt=%0d want %0d", e.name, bus.frame_cnt, e.fc); end
    exp_q.push_back('{"vb_ipl_next_clk", 3'b101, 8'd1});
    cyc();
    e = exp_q.pop_front(); n_chk += 2;
    if (bus.ipl_n !== e.ipl) begin n_err++; $display("FAIL %s ipl_n=%b want %b", e.name, bus.ipl_n, e.ipl); end
    if (bus.frame_cnt !== e.fc) begin n_err++; $display("FAIL %s frame_cnt=%0d want %0d", e.name, bus.frame_cnt, e.fc); end
  endtask

  task automatic test_iack();
    logic [2:0] lvls [3];
    logic [2:0] exps [3];
    lvls = '{3'd5, 3'd4, 3'd2};
    exps = '{3'b101, 3'b101, 3'b111};
    for (int i = 0; i < 3; i++) begin
      exp_q.push_back('{$sformatf("iack_lvl%0d", lvls[i]), exps[i], exp_fc});
      ack(lvls[i]);
      e = exp_q.pop_front(); n_chk++;
      if (bus.ipl_n !== e.ipl) begin n_err++; $display("FAIL %s ipl_n=%b want %b", e.name, bus.ipl_n, e.ipl); end
    end
  endtask

  task automatic test_cen_gate();
    VB = 1'b0; cyc(2);
    cen8 = 1'b0; VB = 1'b1; cyc(4);
    exp_q.push_back('{"cen_low_no_edge", 3'b111, exp_fc});
    e = exp_q.pop_front(); n_chk += 2;
    if (bus.ipl_n !== e.ipl) begin n_err++; $display("FAIL %s ipl_n=%b want %b", e.name, bus.ipl_n, e.ipl); end
    if (bus.frame_cnt !== e.fc) begin n_err++; $display("FAIL %s frame_cnt=%0d want %0d", e.name, bus.frame_cnt, e.fc); end
    cen8 = 1'b1; exp_fc = exp_fc + 8'd1;
    exp_q.push_back('{"cen_high_edge", 3'b101, exp_fc});
    cyc(2);
    e = exp_q.pop_front(); n_chk += 2;
    if (bus.ipl_n !== e.ipl) begin n_err++; $display("FAIL %s ipl_n=%b want %b", e.name, bus.ipl_n, e.ipl); end
    if (bus.frame_cnt !== e.fc) begin n_err++; $display("FAIL %s frame_cnt=%0d want %0d", e.name, bus.frame_cnt, e.fc); end
    ack(3'd2);
  endtask

  task automatic test_absorb();
    vb_edge(); vb_edge();
    exp_q.push_back('{"absorb_repeat", 3'b101, exp_fc});
    e = exp_q.pop_front(); n_chk += 2;
    if (bus.ipl_n !== e.ipl) begin n_err++; $display("FAIL %s ipl_n=%b want %b", e.name, bus.ipl_n, e.ipl); end
    if (bus.frame_cnt !== e.fc) begin n_err++; $display("FAIL %s frame_cnt=%0d want %0d", e.name, bus.frame_cnt, e.fc); end
    exp_q.push_back('{"absorb_single_ack", 3'b111, exp_fc});
    ack(3'd2);
    e = exp_q.pop_front(); n_chk++;
    if (bus.ipl_n !== e.ipl) begin n_err++; $display("FAIL %s ipl_n=%b want %b", e.name, bus.ipl_n, e.ipl); end
  endtask

  task automatic test_set_vs_clear();
    VB = 1'b0; cyc(2);
    VB = 1'b1; bus.iack = 1'b1; bus.iack_lvl = 3'd2; cyc();
    bus.iack = 1'b0; exp_fc = exp_fc + 8'd1;
    exp_q.push_back('{"set_beats_clear", 3'b101, exp_fc});
    cyc();
    e = exp_q.pop_front(); n_chk += 2;
    if (bus.ipl_n !== e.ipl) begin n_err++; $display("FAIL %s ipl_n=%b want %b", e.name, bus.ipl_n, e.ipl); end
    if (bus.frame_cnt !== e.fc) begin n_err++; $display("FAIL %s frame_cnt=%0d want %0d", e.name, bus.frame_cnt, e.fc); end
    ack(3'd2);
  endtask

`ifdef JTCPS1_RASTER_EN
  task automatic lines_until_fire(input string tag, input int nfire);
    for (int p = 1; p <= nfire; p++) begin
      exp_q.push_back('{$sformatf("%s_line%0d", tag, p), (p == nfire) ? 3'b011 : 3'b111, exp_fc});
      start = 1'b1; cyc();
      start = 1'b0; cyc();
      e = exp_q.pop_front(); n_chk++;
      if (bus.ipl_n !== e.ipl) begin n_err++; $display("FAIL %s ipl_n=%b want %b", e.name, bus.ipl_n, e.ipl); end
    end
  endtask

  task automatic test_raster();
    bus.raster_we = 1'b1; bus.raster_din = 9'd10; cyc();
    bus.raster_we = 1'b0; cyc();
    lines_until_fire("rast_a", 11);
    exp_q.push_back('{"rast_ack", 3'b111, exp_fc});
    ack(3'd4);
    e = exp_q.pop_front(); n_chk++;
    if (bus.ipl_n !== e.ipl) begin n_err++; $display("FAIL %s ipl_n=%b want %b", e.name, bus.ipl_n, e.ipl); end
    lines_until_fire("rast_b", 11);
  endtask

  task automatic test_priority();
    logic [2:0] lvls [2];
    logic [2:0] exps [2];
    lvls = '{3'd4, 3'd2};
    exps = '{3'b101, 3'b111};
    vb_edge();
    exp_q.push_back('{"both_pending", 3'b011, exp_fc});
    e = exp_q.pop_front(); n_chk += 2;
    if (bus.ipl_n !== e.ipl) begin n_err++; $display("FAIL %s ipl_n=%b want %b", e.name, bus.ipl_n, e.ipl); end
    if (bus.frame_cnt !== e.fc) begin n_err++; $display("FAIL %s frame_cnt=%0d want %0d", e.name, bus.frame_cnt, e.fc); end
    for (int i = 0; i < 2; i++) begin
      exp_q.push_back('{$sformatf("prio_ack%0d", lvls[i]), exps[i], exp_fc});
      ack(lvls[i]);
      e = exp_q.pop_front(); n_chk++;
      if (bus.ipl_n !== e.ipl) begin n_err++; $display("FAIL %s ipl_n=%b want %b", e.name, bus.ipl_n, e.ipl); end
    end
  endtask

  task automatic test_we_start();
    bus.raster_we = 1'b1; bus.raster_din = 9'd0; cyc();
    bus.raster_we = 1'b0; cyc();
    lines_until_fire("rload0_a", 1);
    ack(3'd4);
    lines_until_fire("rload0_b", 1);
    ack(3'd4);
    bus.raster_we = 1'b1; bus.raster_din = 9'd3; start = 1'b1; cyc();
    bus.raster_we = 1'b0; start = 1'b0;
    exp_q.push_back('{"we_beats_start", 3'b111, exp_fc});
    cyc();
    e = exp_q.pop_front(); n_chk++;
    if (bus.ipl_n !== e.ipl) begin n_err++; $display("FAIL %s ipl_n=%b want %b", e.name, bus.ipl_n, e.ipl); end
    lines_until_fire("we_reload", 4);
    ack(3'd4);
  endtask
`else
  task automatic test_no_raster();
    bus.raster_we = 1'b1; bus.raster_din = 9'd0; cyc();
    bus.raster_we = 1'b0; cyc();
    for (int p = 1; p <= 12; p++) begin
      exp_q.push_back('{$sformatf("no_raster_line%0d", p), 3'b111, exp_fc});
      start = 1'b1; bus.raster_we = (p == 6); cyc();
      start = 1'b0; bus.raster_we = 1'b0; cyc();
      e = exp_q.pop_front(); n_chk++;
      if (bus.ipl_n !== e.ipl) begin n_err++; $display("FAIL %s ipl_n=%b want %b", e.name, bus.ipl_n, e.ipl); end
    end
  endtask
`endif

  task automatic test_reset_mid();
    vb_edge();
    #2 rst_n = 1'b0;
    #1;
    exp_fc = 8'd0;
    exp_q.push_back('{"reset_mid_frame", 3'b111, 8'd0});
    e = exp_q.pop_front(); n_chk += 2;
    if (bus.ipl_n !== e.ipl) begin n_err++; $display("FAIL %s ipl_n=%b want %b", e.name, bus.ipl_n, e.ipl); end
    if (bus.frame_cnt !== e.fc) begin n_err++; $display("FAIL %s frame_cnt=%0d want %0d", e.name, bus.frame_cnt, e.fc); end
    cyc(2);
    rst_n = 1'b1; cyc(3);
  endtask

  initial begin
    rst_n = 1'b0; cen8 = 1'b1; VB = 1'b1; start = 1'b0;
    bus.raster_we = 1'b0; bus.raster_din = 9'd0;
    bus.iack = 1'b0; bus.iack_lvl = 3'd0;
    test_reset();
    test_vblank();
    test_iack();
    test_cen_gate();
    test_absorb();
    test_set_vs_clear();
`ifdef JTCPS1_RASTER_EN
    test_raster();
    test_priority();
    test_we_start();
`else
    test_no_raster();
`endif
    test_reset_mid();
    $display("Result: errors=%0d of %0d checks", n_err, n_chk);
    $finish;
  end

endmodule

// File: doc/jtcps1_irqgen.md
JTCPS1_IRQGEN -- requirements
Module: jtcps1_irqgen

Interface
REQ-001 SHALL have parameter VINT_LEVEL, default 3'd2, which is the 68000 IPL level for the vertical-blank interrupt.
REQ-002 SHALL have parameter RINT_LEVEL, default 3'd4, which is the 68000 IPL level for the raster interrupt; it must be greater than VINT_LEVEL.
REQ-003 SHALL have port clk, input, 1 bit: the single system clock.
REQ-004 SHALL have port rst_n, input, 1 bit: asynchronous, active-low reset.
REQ-005 SHALL have port cen8, input, 1 bit: pixel clock enable, shared with the video timing generator.
REQ-006 SHALL have port VB, input, 1 bit: vertical blank from the timing generator.
REQ-007 SHALL have port start, input, 1 bit: line-start pulse, one cen8 tick wide, from the timing generator.
REQ-008 SHALL have port raster_we, input, 1 bit: CPU write strobe to the raster line register, one clk wide.
REQ-009 SHALL have port raster_din, input, 9 bits: raster line count written by the CPU.
REQ-010 SHALL have port iack, input, 1 bit: CPU interrupt-acknowledge strobe, one clk wide.
REQ-011 SHALL have port iack_lvl, input, 3 bits: the level being acknowledged.
REQ-012 SHALL have port ipl_n, output, 3 bits: active-low encoded interrupt priority level to the 68000.
REQ-013 SHALL have port frame_cnt, output, 8 bits: frame counter, incremented once per VB rising edge.

Function
REQ-014 SHALL detect a VB rising edge only on cycles where cen8 is high, comparing against VB as sampled on the previous cen8 cycle.
REQ-015 SHALL, on a VB rising edge, set vint_pend and increment frame_cnt modulo 256.
REQ-016 SHALL hold a 9-bit raster counter rcnt and a 9-bit reload register rload.
REQ-017 SHALL, on raster_we, load rload and rcnt with raster_din on that clk, regardless of cen8.
REQ-018 SHALL, when cen8 and start are both high and no raster_we occurs: if rcnt is 0, set rint_pend and reload rcnt from rload; otherwise decrement rcnt by 1.
REQ-019 SHALL give raster_we priority when raster_we and a start pulse fall on the same clk; the start pulse is then ignored for counting.
REQ-020 SHALL treat rload = 0 as firing on every line.
REQ-021 SHALL let the counter reload take effect on the start pulse itself, with no extra line of latency.
REQ-022 SHALL, on iack, clear rint_pend if iack_lvl equals RINT_LEVEL, and clear vint_pend if iack_lvl equals VINT_LEVEL.
REQ-023 SHALL ignore an iack whose iack_lvl matches neither level.
REQ-024 SHALL, when a set and an iack-clear of the same pending bit occur on the same clk, leave the bit set.
REQ-025 SHALL keep each pending bit set until it is acknowledged; a repeated event while pending is absorbed, with no counting.
REQ-026 SHALL register ipl_n as ~RINT_LEVEL if rint_pend, else ~VINT_LEVEL if vint_pend, else 3'b111.
REQ-027 SHALL update ipl_n one clk after the change in the pending bits.
REQ-028 SHALL sample iack every clk, not gated by cen8.

Reset
REQ-029 SHALL, while rst_n is low, drive ipl_n = 3'b111, vint_pend = 0, rint_pend = 0, frame_cnt = 0, rcnt = 9'h1FF, rload = 9'h1FF, and the VB history to 1.
REQ-030 SHALL, because the VB history resets to 1, produce no VB edge in the first frame if VB is already high when reset is released.
REQ-031 SHALL drop any pending interrupt immediately on a reset asserted mid-frame.

Configuration
REQ-032 SHALL, with JTCPS1_RASTER_EN defined, include the raster counter, rload and rint_pend as specified above.
REQ-033 SHALL, without JTCPS1_RASTER_EN, omit the raster logic: rint_pend is constant 0, raster_we, raster_din and start are ignored, and ipl_n reflects only vint_pend.

Structure
REQ-034 SHALL place the level constants (VINT_LEVEL and RINT_LEVEL defaults) and the rcnt reset value in the shared package jtcps1_pkg.
REQ-035 SHALL use one sub-module, jtcps1_edge (a cen-gated rising-edge detector with a reset value input), for the VB edge.

Verification
REQ-036 SHALL cover: reset with VB high, release, VB falls then rises -> frame_cnt = 1, ipl_n = 3'b101 one clk after the edge.
REQ-037 SHALL cover: write raster_din = 9'd10 -> rint fires on the 11th start pulse, ipl_n = 3'b011, then fires again 11 pulses later.
REQ-038 SHALL cover: vint and rint both pending -> ipl_n = 3'b011; iack with iack_lvl = 4 -> ipl_n = 3'b101; iack with iack_lvl = 2 -> ipl_n = 3'b111.
REQ-039 SHALL cover: VB rising edge and iack with iack_lvl = 2 on the same clk -> vint_pend stays 1.
REQ-040 SHALL cover: raster_we on the same clk as start with rcnt = 0 -> no rint, rcnt = raster_din.
REQ-041 SHALL cover: a build without JTCPS1_RASTER_EN given raster writes and start pulses -> ipl_n never equals 3'b011.
